// File: rtl/sclk_edge_counter.sv
// Counts selected edges of a slow asynchronous strobe after synchronising it into the CLK domain.
// Provides wrap detection at a configurable terminal count and a sticky overflow flag.
module sclk_edge_counter #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}},
    parameter int              SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SCLK,
    input  logic             EN,
    input  logic             CLR,
    input  logic [1:0]       EDGE_SEL,
    output logic [WIDTH-1:0] CNTVAL,
    output logic             EDGE_PULSE,
    output logic             OV,
    output logic             OV_STICKY
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   armed;

    logic             s_last;
    logic             rise;
    logic             fall;
    logic             qual_edge;
    logic [WIDTH-1:0] cnt_next;
    logic             ov_next;
    logic             sticky_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SCLK};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Hold off edge detection until the chain and history flop carry real SCLK samples.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else if (!armed) begin
            if (arm_cnt == ARM_W'(SYNC_STAGES))
                armed <= 1'b1;
            else
                arm_cnt <= arm_cnt + ARM_W'(1);
        end
    end

    assign s_last = sync_q[SYNC_STAGES-1];
    assign rise   = armed & s_last & ~hist_q;
    assign fall   = armed & ~s_last & hist_q;

    always_comb begin
        qual_edge = 1'b0;
        case (EDGE_SEL)
            2'b00:   qual_edge = fall;
            2'b01:   qual_edge = rise;
            2'b10:   qual_edge = rise | fall;
            default: qual_edge = 1'b0;
        endcase
        qual_edge = qual_edge & EN;
    end

    // A clear wins over a same-cycle edge; the edge is still reported on EDGE_PULSE.
    always_comb begin
        cnt_next    = CNTVAL;
        ov_next     = 1'b0;
        sticky_next = OV_STICKY;
        if (CLR) begin
            cnt_next    = '0;
            sticky_next = 1'b0;
        end else if (qual_edge) begin
            if (CNTVAL >= CNT_MAX) begin
                cnt_next    = '0;
                ov_next     = 1'b1;
                sticky_next = 1'b1;
            end else begin
                cnt_next = CNTVAL + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CNTVAL     <= '0;
            EDGE_PULSE <= 1'b0;
            OV         <= 1'b0;
            OV_STICKY  <= 1'b0;
        end else begin
            CNTVAL     <= cnt_next;
            EDGE_PULSE <= qual_edge;
            OV         <= ov_next;
            OV_STICKY  <= sticky_next;
        end
    end

endmodule

// File: tb/tb_sclk_edge_counter.sv
// Directed bench for sclk_edge_counter: a default 8-bit instance and a 4-bit instance wrapping at 9.
module tb_sclk_edge_counter;

    logic       CLK;
    logic       RST;
    logic       SCLK;
    logic       EN;
    logic       CLR;
    logic [1:0] EDGE_SEL;

    logic [7:0] cnt8;
    logic       pulse8;
    logic       ov8;
    logic       sticky8;

    logic [3:0] cnt4;
    logic       pulse4;
    logic       ov4;
    logic       sticky4;

    int checks = 0;
    int errors = 0;
    int pulse_total8 = 0;
    int ov_total4 = 0;
    int base;

    sclk_edge_counter dut8 (
        .CLK(CLK), .RST(RST), .SCLK(SCLK), .EN(EN), .CLR(CLR), .EDGE_SEL(EDGE_SEL),
        .CNTVAL(cnt8), .EDGE_PULSE(pulse8), .OV(ov8), .OV_STICKY(sticky8)
    );

    sclk_edge_counter #(.WIDTH(4), .CNT_MAX(4'd9), .SYNC_STAGES(2)) dut4 (
        .CLK(CLK), .RST(RST), .SCLK(SCLK), .EN(EN), .CLR(CLR), .EDGE_SEL(EDGE_SEL),
        .CNTVAL(cnt4), .EDGE_PULSE(pulse4), .OV(ov4), .OV_STICKY(sticky4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Each one-cycle pulse is seen at exactly one rising edge, before that edge updates it.
    always @(posedge CLK) begin
        pulse_total8 += int'(pulse8);
        ov_total4    += int'(ov4);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, need completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, need %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic applyStimulus(input int periods);
        for (int i = 0; i < periods; i++) begin
            SCLK = 1'b1;
            tick(4);
            SCLK = 1'b0;
            tick(4);
        end
    endtask

    task automatic doReset(input logic sclk_level);
        SCLK = sclk_level;
        RST  = 1'b1;
        tick(2);
        RST  = 1'b0;
        tick(6);
    endtask

    initial begin
        RST = 1'b1; SCLK = 1'b0; EN = 1'b1; CLR = 1'b0; EDGE_SEL = 2'b00;
        tick(2);
        checkOutput("reset_cnt", 32'(cnt8), 32'd0);
        checkOutput("reset_pulse", 32'(pulse8), 32'd0);
        checkOutput("reset_ov", 32'(ov8), 32'd0);
        checkOutput("reset_sticky", 32'(sticky8), 32'd0);
        RST = 1'b0;
        tick(6);

        // Five falling edges with the default configuration
        base = pulse_total8;
        applyStimulus(5);
        checkOutput("fall5_cnt", 32'(cnt8), 32'd5);
        checkOutput("fall5_pulses", 32'(pulse_total8 - base), 32'd5);
        checkOutput("fall5_ov", 32'(ov8), 32'd0);
        checkOutput("fall5_sticky", 32'(sticky8), 32'd0);

        // SCLK idling high across reset release must not count
        base = pulse_total8;
        doReset(1'b1);
        checkOutput("idle_high_cnt", 32'(cnt8), 32'd0);
        checkOutput("idle_high_pulses", 32'(pulse_total8 - base), 32'd0);

        // Exact latency of a single falling edge
        SCLK = 1'b0;
        tick(1);
        checkOutput("lat_e0_cnt", 32'(cnt8), 32'd0);
        checkOutput("lat_e0_pulse", 32'(pulse8), 32'd0);
        tick(1);
        checkOutput("lat_e1_cnt", 32'(cnt8), 32'd0);
        checkOutput("lat_e1_pulse", 32'(pulse8), 32'd0);
        tick(1);
        checkOutput("lat_e2_cnt", 32'(cnt8), 32'd1);
        checkOutput("lat_e2_pulse", 32'(pulse8), 32'd1);
        tick(1);
        checkOutput("lat_e3_pulse", 32'(pulse8), 32'd0);

        // Wrap at CNT_MAX=9 on the 4-bit instance, then clear
        doReset(1'b0);
        base = ov_total4;
        applyStimulus(9);
        checkOutput("w4_cnt9", 32'(cnt4), 32'd9);
        checkOutput("w4_ov_before", 32'(ov_total4 - base), 32'd0);
        checkOutput("w4_sticky_before", 32'(sticky4), 32'd0);
        applyStimulus(1);
        checkOutput("w4_cnt_wrap", 32'(cnt4), 32'd0);
        checkOutput("w4_ov_once", 32'(ov_total4 - base), 32'd1);
        checkOutput("w4_sticky_set", 32'(sticky4), 32'd1);
        checkOutput("w8_cnt10", 32'(cnt8), 32'd10);
        CLR = 1'b1;
        tick(1);
        CLR = 1'b0;
        tick(1);
        checkOutput("w4_clr_cnt", 32'(cnt4), 32'd0);
        checkOutput("w4_clr_sticky", 32'(sticky4), 32'd0);
        checkOutput("w8_clr_cnt", 32'(cnt8), 32'd0);

        // Both edges, then the frozen mode
        doReset(1'b0);
        EDGE_SEL = 2'b10;
        base = pulse_total8;
        applyStimulus(3);
        checkOutput("both_cnt", 32'(cnt8), 32'd6);
        checkOutput("both_pulses", 32'(pulse_total8 - base), 32'd6);
        EDGE_SEL = 2'b11;
        base = pulse_total8;
        applyStimulus(3);
        checkOutput("none_cnt", 32'(cnt8), 32'd6);
        checkOutput("none_pulses", 32'(pulse_total8 - base), 32'd0);

        // Edges during EN=0 are dropped, not deferred
        EDGE_SEL = 2'b00;
        EN = 1'b0;
        base = pulse_total8;
        applyStimulus(2);
        EN = 1'b1;
        tick(8);
        checkOutput("en_off_cnt", 32'(cnt8), 32'd6);
        checkOutput("en_off_pulses", 32'(pulse_total8 - base), 32'd0);

        // Clear coinciding with a qualified edge
        SCLK = 1'b1;
        tick(4);
        SCLK = 1'b0;
        tick(2);
        CLR = 1'b1;
        tick(1);
        CLR = 1'b0;
        checkOutput("clr_edge_cnt", 32'(cnt8), 32'd0);
        checkOutput("clr_edge_pulse", 32'(pulse8), 32'd1);
        tick(2);

        // Asynchronous reset between clock edges
        applyStimulus(3);
        checkOutput("pre_rst_cnt", 32'(cnt8), 32'd3);
        RST = 1'b1;
        #1;
        checkOutput("async_rst_cnt", 32'(cnt8), 32'd0);
        checkOutput("async_rst_pulse", 32'(pulse8), 32'd0);
        tick(1);
        RST = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sclk_edge_counter.md
Name:
sclk_edge_counter

Overview:
Parametrised, synchronised edge counter for a slow external strobe (SCLK) sampled in the CLK domain. It generalises the fixed 8-bit falling-edge counter to configurable width and terminal value, with a multi-stage synchroniser and a runtime edge-mode select. It also adds enable, synchronous clear, post-reset arming, and wrap/overflow reporting. It feeds noise-pattern index and address generation downstream.

Parameters:
WIDTH, 8, counter width in bits (1..32).
CNT_MAX, 2**WIDTH-1, terminal count; wrap occurs after this value; legal range 1..2**WIDTH-1.
SYNC_STAGES, 2, synchroniser flop count on SCLK; minimum 2.

Ports:
CLK  input  1  system clock, rising edge active.
RST  input  1  asynchronous reset, active-high.
SCLK  input  1  asynchronous strobe to be counted.
EN  input  1  count enable; edges are ignored while low, not deferred.
CLR  input  1  synchronous clear of the count and sticky flag.
EDGE_SEL  input  2  00 = falling, 01 = rising, 10 = both, 11 = none (count frozen).
CNTVAL  output  WIDTH  current count.
EDGE_PULSE  output  1  one-cycle pulse on each qualified, selected edge.
OV  output  1  one-cycle pulse on wrap from CNT_MAX to 0.
OV_STICKY  output  1  set on wrap; held until CLR or RST.

Behaviour:
- Reset (RST high, asynchronous): CNTVAL = 0, EDGE_PULSE = 0, OV = 0, OV_STICKY = 0.
  - Synchroniser chain and history flop = 0; arming counter = 0; ARMED = 0.
- Synchroniser: chain s[0..SYNC_STAGES-1] plus history flop h, which captures s[SYNC_STAGES-1] each CLK edge.
  - rise = s_last & ~h; fall = ~s_last & h.
- Arming:
  - After RST deasserts, ARMED stays 0 for SYNC_STAGES+1 CLK edges, then goes to 1 and stays there.
  - While ARMED = 0, rise and fall are suppressed. This means an SCLK that idles high across reset never produces a spurious edge.
- Qualified edge: ARMED & EN & ((EDGE_SEL==00 & fall) | (EDGE_SEL==01 & rise) | (EDGE_SEL==10 & (rise|fall))).
- Latency: an SCLK transition captured by s[0] at CLK edge 0 gives the following timing.
  - The edge condition is true during the cycle after edge SYNC_STAGES-1.
  - EDGE_PULSE is registered and goes high for the cycle after edge SYNC_STAGES.
  - CNTVAL updates at edge SYNC_STAGES; with the default, that is edge 2.
- Counting on a qualified edge:
  - If CNTVAL >= CNT_MAX: CNTVAL <= 0, OV <= 1 for one cycle, OV_STICKY <= 1.
  - Otherwise CNTVAL <= CNTVAL + 1 with WIDTH-bit arithmetic; OV <= 0.
- No qualified edge: CNTVAL holds; OV <= 0.
- CLR priority over counting: CNTVAL <= 0, OV <= 0, OV_STICKY <= 0.
  - An edge qualified in the same cycle is discarded and does not count; EDGE_PULSE still fires.
  - CLR does not affect the synchroniser or ARMED.
- EDGE_SEL changes take effect on the next cycle's qualification. The synchroniser keeps tracking regardless of EN or EDGE_SEL, so re-enabling never produces a stale edge.
- SCLK pulses narrower than about 2 CLK periods at either level may be missed; this is legal and not an error.
- RST asserted mid-operation: all state clears immediately; arming restarts on deassertion.

Test Plan:
1. RST, then EN=1, EDGE_SEL=00; drive 5 SCLK periods, each level held 4 CLK -> CNTVAL=5, 5 EDGE_PULSE pulses, OV=0, OV_STICKY=0.
2. Single SCLK 1->0 captured at CLK edge 0, SYNC_STAGES=2 -> CNTVAL changes 0->1 exactly at edge 2; EDGE_PULSE high for the cycle after edge 2.
3. WIDTH=4, CNT_MAX=9; 10 falling edges -> CNTVAL 9 after the 9th edge, 0 after the 10th; OV pulses once, OV_STICKY=1. Then pulse CLR -> CNTVAL=0, OV_STICKY=0.
4. EDGE_SEL=10; 3 SCLK periods -> CNTVAL=6. Switch to 11; 3 more periods -> CNTVAL stays 6, no EDGE_PULSE.
5. SCLK held 1 through reset release -> CNTVAL=0, no EDGE_PULSE. EN=0 during 2 falling edges, then EN=1 with no further edges -> CNTVAL unchanged.
6. CLR asserted in the same cycle as a qualified edge -> CNTVAL=0 next cycle. Count to 3, then assert RST asynchronously between CLK edges -> CNTVAL=0 before the next CLK edge.
